tsu_sfd_stamp: RTL and testbench
================================

// Module: tsu_sfd_stamp
// PURPOSE
//  Next-gen ingress timestamp unit for the GMII/MII receive path, all logic in gmii_clk.
//  Per frame: capture RTC time at the SFD byte, add fixed latency compensation with ns->sec carry,
//  parse L2 PTP (ethertype 0x88F7) msgType/sequenceId, filter by mask.
//  Queue matching records in a parametrised sync FIFO, with overflow counting.
//  rtc_sec/rtc_ns are an RTC copy already in the gmii_clk domain (supplied by the RTC block).
// PARAMETERS
//  SEC_W   48  seconds field width
//  NS_W    32  nanoseconds field width
//  DEPTH   16  FIFO entries; power of 2, 2..256
//  LAT_NS  0   ns added to captured time; 0 <= LAT_NS < 1e9
//  localparams: AW=$clog2(DEPTH); REC_W=SEC_W+NS_W+20
// PORTS
//  gmii_clk        in   1      rx clock
//  rst             in   1      reset, asynchronous, active-high
//  giga_mode       in   1      1=8b GMII, 0=4b MII nibbles on gmii_data[3:0], low nibble first
//  gmii_ctrl       in   1      rx data valid
//  gmii_data       in   8      rx data
//  ptp_msgid_mask  in   16     bit n=1 enables msgType n
//  rtc_sec         in   SEC_W  RTC seconds
//  rtc_ns          in   NS_W   RTC nanoseconds, always < 1e9
//  q_rd_en         in   1      pop request
//  q_rd_data       out  REC_W  {sec, ns, msgType[3:0], seqId[15:0]}
//  q_rd_valid      out  1      q_rd_data valid, single-cycle pulse
//  q_empty         out  1      FIFO empty
//  q_count         out  AW+1   FIFO occupancy
//  drop_clr        in   1      clear drop_cnt
//  drop_cnt        out  16     saturating count of records lost to full FIFO
//  sfd_pulse       out  1      1-cycle pulse on SFD detect
// BEHAVIOUR
//  Reset: all outputs 0 (q_empty=1), FIFO pointers/count 0, FSM IDLE. Reset mid-frame discards the frame.
//  Gearbox: giga_mode=1 gives byte_vld=gmii_ctrl, 1 cycle latency. giga_mode=0 pairs nibbles;
//   byte_vld on each 2nd ctrl cycle. A nibble phase toggles on ctrl and clears when ctrl is low.
//  FSM, advancing on byte_vld:
//   IDLE -> PRE on byte 0x55.
//   PRE: stay on 0x55; 0xD5 -> FRAME (sfd_pulse, capture); any other byte -> DROP.
//   FRAME/DROP: byte counter bcnt starts at 0 on the first DA byte and saturates at 2047.
//   Any state -> IDLE one cycle after ctrl deasserts (frame end).
//  Capture: on the SFD cycle, ts_ns=rtc_ns+LAT_NS and ts_sec=rtc_sec.
//   Next cycle, if ts_ns>=1e9: ts_ns-=1e9 and ts_sec+=1 (sec wraps modulo 2^SEC_W).
//  Parse: ethertype at bcnt 12-13 = 0x88F7; msgType=byte14[3:0]; seqId=bytes 44 (MSB) and 45.
//  Record eligible if: ethertype matched, bcnt reached 46, and ptp_msgid_mask[msgType]=1.
//   Runt frames and frames aborted before SFD are never written.
//  Write: at frame end (IDLE entry cycle), an eligible record is pushed.
//   Push accepted if count<DEPTH, or if count==DEPTH and a pop happens in the same cycle.
//   Otherwise the record is dropped and drop_cnt increments, saturating at 0xFFFF.
//   drop_clr wins over a simultaneous increment.
//  Read: when q_rd_en=1 and FIFO not empty, q_rd_data and q_rd_valid=1 are registered next cycle.
//   q_rd_en on empty is ignored (no valid, no pointer move).
//   Simultaneous push+pop leaves count unchanged; pointers wrap modulo DEPTH.
//  q_rd_data holds its last value between pops.
// CONFIGURATION
//  TSU_VLAN_EN defined:
//   if bcnt 12-13 = 0x8100, one 802.1Q tag is skipped; all later offsets +4
//   (ethertype 16-17, msgType 18, seqId 48-49, eligibility bcnt 50).
//  TSU_VLAN_EN undefined: tagged frames never match.
// TESTING
//  giga, LAT_NS=0, rtc=(5 s, 100 ns), PTP Sync msgType 0 seqId 0x1234, mask=0x0001
//   -> one record {5, 100, 0, 0x1234}; q_count=1.
//  LAT_NS=200, rtc_ns=999_999_900, sec=7 -> record sec=8, ns=100.
//  MII mode, same frame as nibbles -> identical record to giga case; sfd_pulse exactly once.
//  mask=0x0001, frame with msgType 1 -> no record. Frame truncated at byte 30 -> no record, drop_cnt=0.
//  DEPTH=4: send 6 eligible frames without reads -> q_count=4, drop_cnt=2.
//   Then pop 4 -> seqIds in send order, q_empty=1. A 5th pop gives no q_rd_valid.
//  TSU_VLAN_EN: tagged 0x8100 PTP frame -> record written. Undefined -> none.
//   Assert rst mid-frame -> FIFO empty, no record.

Source files
------------

// File: rtl/tsu_sfd_stamp.sv
// Ingress timestamp unit: SFD-time capture with latency compensation, L2 PTP parse, record FIFO.
// Optional TSU_VLAN_EN: skip one 802.1Q tag before the PTP ethertype.
module tsu_sfd_stamp #(
  parameter int SEC_W  = 48,
  parameter int NS_W   = 32,
  parameter int DEPTH  = 16,
  parameter int LAT_NS = 0,
  localparam int AW    = $clog2(DEPTH),
  localparam int REC_W = SEC_W + NS_W + 20
) (
  input  logic             gmii_clk,
  input  logic             rst,
  input  logic             giga_mode,
  input  logic             gmii_ctrl,
  input  logic [7:0]       gmii_data,
  input  logic [15:0]      ptp_msgid_mask,
  input  logic [SEC_W-1:0] rtc_sec,
  input  logic [NS_W-1:0]  rtc_ns,
  input  logic             q_rd_en,
  output logic [REC_W-1:0] q_rd_data,
  output logic             q_rd_valid,
  output logic             q_empty,
  output logic [AW:0]      q_count,
  input  logic             drop_clr,
  output logic [15:0]      drop_cnt,
  output logic             sfd_pulse
);

  typedef enum logic [1:0] {IDLE, PRE, FRAME, DROP} state_t;

  localparam logic [NS_W:0] NS_WRAP = (NS_W+1)'(1_000_000_000);
  localparam logic [NS_W:0] NS_LAT  = (NS_W+1)'(LAT_NS);

  state_t           state, state_next;
  logic             nib_phase, ctrl_d, byte_vld;
  logic [3:0]       nib_lo;
  logic [7:0]       rx_byte;
  logic             sfd_hit, frame_end;
  logic [10:0]      bcnt, off;
  logic [7:0]       et_hi;
  logic             et_match, seq_done;
  logic [3:0]       msg_type;
  logic [15:0]      seq_id;
  logic [NS_W:0]    ts_ns;
  logic [SEC_W-1:0] ts_sec;
  logic             ts_fix;
  logic             push_req, push, pop;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [REC_W-1:0] mem [DEPTH];

  // Gearbox: GMII bytes pass through; MII nibbles pair low-first into a byte
  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      nib_phase <= 1'b0;
      nib_lo    <= '0;
      ctrl_d    <= 1'b0;
      byte_vld  <= 1'b0;
      rx_byte   <= '0;
    end else begin
      ctrl_d <= gmii_ctrl;
      if (giga_mode) begin
        nib_phase <= 1'b0;
        byte_vld  <= gmii_ctrl;
        rx_byte   <= gmii_data;
      end else begin
        byte_vld  <= gmii_ctrl && nib_phase;
        nib_phase <= gmii_ctrl ? ~nib_phase : 1'b0;
        if (gmii_ctrl && !nib_phase) nib_lo <= gmii_data[3:0];
        if (gmii_ctrl && nib_phase) rx_byte <= {gmii_data[3:0], nib_lo};
      end
    end
  end

  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sfd_hit    = 1'b0;
    frame_end  = 1'b0;
    if (state != IDLE && !ctrl_d) begin
      state_next = IDLE;
      frame_end  = 1'b1;
    end else if (byte_vld) begin
      case (state)
        IDLE: if (rx_byte == 8'h55) state_next = PRE;
        PRE: begin
          if (rx_byte == 8'hD5) begin
            state_next = FRAME;
            sfd_hit    = 1'b1;
          end else if (rx_byte != 8'h55) begin
            state_next = DROP;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TSU_VLAN_EN
  logic vlan;
  assign off = vlan ? 11'd4 : 11'd0;
`else
  assign off = 11'd0;
`endif

  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      bcnt     <= '0;
      et_hi    <= '0;
      et_match <= 1'b0;
      seq_done <= 1'b0;
      msg_type <= '0;
      seq_id   <= '0;
`ifdef TSU_VLAN_EN
      vlan     <= 1'b0;
`endif
    end else if (sfd_hit || state == IDLE) begin
      bcnt     <= '0;
      et_match <= 1'b0;
      seq_done <= 1'b0;
`ifdef TSU_VLAN_EN
      vlan     <= 1'b0;
`endif
    end else if (byte_vld && (state == FRAME || state == DROP)) begin
      if (bcnt != 11'd2047) bcnt <= bcnt + 11'd1;
      if (state == FRAME) begin
        if (bcnt == 11'd12 + off) et_hi <= rx_byte;
        if (bcnt == 11'd13 + off) begin
          if ({et_hi, rx_byte} == 16'h88F7) et_match <= 1'b1;
`ifdef TSU_VLAN_EN
          if (off == 11'd0 && {et_hi, rx_byte} == 16'h8100) vlan <= 1'b1;
`endif
        end
        if (bcnt == 11'd14 + off) msg_type <= rx_byte[3:0];
        if (bcnt == 11'd44 + off) seq_id[15:8] <= rx_byte;
        if (bcnt == 11'd45 + off) begin
          seq_id[7:0] <= rx_byte;
          seq_done    <= 1'b1;
        end
      end
    end
  end

  // Capture with latency added; the ns->sec carry is resolved one cycle later
  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      ts_ns     <= '0;
      ts_sec    <= '0;
      ts_fix    <= 1'b0;
      sfd_pulse <= 1'b0;
    end else begin
      sfd_pulse <= sfd_hit;
      if (sfd_hit) begin
        ts_ns  <= {1'b0, rtc_ns} + NS_LAT;
        ts_sec <= rtc_sec;
        ts_fix <= 1'b1;
      end else if (ts_fix) begin
        ts_fix <= 1'b0;
        if (ts_ns >= NS_WRAP) begin
          ts_ns  <= ts_ns - NS_WRAP;
          ts_sec <= ts_sec + SEC_W'(1);
        end
      end
    end
  end

  assign push_req = frame_end && state == FRAME && et_match && seq_done && ptp_msgid_mask[msg_type];
  assign pop      = q_rd_en && (q_count != '0);
  assign push     = push_req && ((q_count < (AW+1)'(DEPTH)) || pop);
  assign q_empty  = (q_count == '0);

  always_ff @(posedge gmii_clk) begin
    if (push) mem[wr_ptr] <= {ts_sec, ts_ns[NS_W-1:0], msg_type, seq_id};
  end

  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      q_rd_data  <= '0;
      q_rd_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      q_rd_valid <= pop;
      if (pop) begin
        q_rd_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (push && !pop)      q_count <= q_count + (AW+1)'(1);
      else if (pop && !push) q_count <= q_count - (AW+1)'(1);
      if (drop_clr) drop_cnt <= '0;
      else if (push_req && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tsu_sfd_stamp.sv
// Directed bench for tsu_sfd_stamp: table of frames plus FIFO-depth, latency-carry and reset sequences.
module tb_tsu_sfd_stamp;

  localparam int REC_W = 100;
`ifdef TSU_VLAN_EN
  localparam logic VLAN_EXP = 1'b1;
`else
  localparam logic VLAN_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             giga_mode = 1'b1;
  logic             gmii_ctrl = 1'b0;
  logic [7:0]       gmii_data = '0;
  logic [15:0]      mask = 16'h0001;
  logic [47:0]      rtc_sec = '0;
  logic [31:0]      rtc_ns = '0;
  logic             rd_en = 1'b0, rd_en_l = 1'b0;
  logic             drop_clr = 1'b0;
  logic [REC_W-1:0] rd_data, rd_data_l;
  logic             rd_valid, rd_valid_l, empty, empty_l, sfd, sfd_l;
  logic [2:0]       count;
  logic [4:0]       count_l;
  logic [15:0]      drops, drops_l;

  int errors = 0, checks = 0, sfd_cnt = 0;

  always #5 clk = ~clk;

  tsu_sfd_stamp #(.DEPTH(4), .LAT_NS(0)) dut (
    .gmii_clk(clk), .rst(rst), .giga_mode(giga_mode), .gmii_ctrl(gmii_ctrl), .gmii_data(gmii_data),
    .ptp_msgid_mask(mask), .rtc_sec(rtc_sec), .rtc_ns(rtc_ns), .q_rd_en(rd_en),
    .q_rd_data(rd_data), .q_rd_valid(rd_valid), .q_empty(empty), .q_count(count),
    .drop_clr(drop_clr), .drop_cnt(drops), .sfd_pulse(sfd));

  tsu_sfd_stamp #(.DEPTH(16), .LAT_NS(200)) dut_l (
    .gmii_clk(clk), .rst(rst), .giga_mode(giga_mode), .gmii_ctrl(gmii_ctrl), .gmii_data(gmii_data),
    .ptp_msgid_mask(mask), .rtc_sec(rtc_sec), .rtc_ns(rtc_ns), .q_rd_en(rd_en_l),
    .q_rd_data(rd_data_l), .q_rd_valid(rd_valid_l), .q_empty(empty_l), .q_count(count_l),
    .drop_clr(drop_clr), .drop_cnt(drops_l), .sfd_pulse(sfd_l));

  typedef struct {
    logic        giga;
    logic        bad_pre;
    logic        vlan;
    logic [15:0] et;
    logic [3:0]  mt;
    logic [15:0] seq;
    int          nbytes;
    logic [15:0] mask;
    logic [47:0] sec;
    logic [31:0] ns;
    logic        exp_rec;
    int          exp_sfd;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(negedge clk);
    if (sfd) sfd_cnt++;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input int i, input logic vlan, input logic [15:0] et,
                                       input logic [3:0] mt, input logic [15:0] seq);
    int o;
    logic [7:0] v;
    o = vlan ? 4 : 0;
    v = 8'(i) ^ 8'hA5;
    if (i < 6) v = 8'h01;
    else if (i < 12) v = 8'h02;
    else if (vlan && i == 12) v = 8'h81;
    else if (vlan && i == 13) v = 8'h00;
    else if (vlan && i == 14) v = 8'h00;
    else if (vlan && i == 15) v = 8'h05;
    else if (i == 12 + o) v = et[15:8];
    else if (i == 13 + o) v = et[7:0];
    else if (i == 14 + o) v = {4'h0, mt};
    else if (i == 44 + o) v = seq[15:8];
    else if (i == 45 + o) v = seq[7:0];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    gmii_ctrl = 1'b1;
    if (giga_mode) begin
      gmii_data = b;
      tick();
    end else begin
      gmii_data = {4'h0, b[3:0]};
      tick();
      gmii_data = {4'h0, b[7:4]};
      tick();
    end
  endtask

  task automatic end_frame();
    gmii_ctrl = 1'b0;
    gmii_data = '0;
    repeat (6) tick();
  endtask

  task automatic send_frame(input logic bad_pre, input logic vlan, input logic [15:0] et,
                            input logic [3:0] mt, input logic [15:0] seq, input int nbytes);
    repeat (7) send_byte(8'h55);
    send_byte(bad_pre ? 8'h12 : 8'hD5);
    for (int i = 0; i < nbytes; i++) send_byte(fbyte(i, vlan, et, mt, seq));
    end_frame();
  endtask

  task automatic pop_main(output logic v, output logic [REC_W-1:0] d);
    rd_en = 1'b1;
    tick();
    v = rd_valid;
    d = rd_data;
    rd_en = 1'b0;
    tick();
  endtask

  task automatic pop_lat(output logic v, output logic [REC_W-1:0] d);
    rd_en_l = 1'b1;
    tick();
    v = rd_valid_l;
    d = rd_data_l;
    rd_en_l = 1'b0;
    tick();
  endtask

  initial begin
    logic             v;
    logic [REC_W-1:0] d;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h88F7, 4'd0, 16'h1234, 64, 16'h0001, 48'd5, 32'd100, 1'b1, 1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h88F7, 4'd0, 16'h1234, 64, 16'h0001, 48'd5, 32'd100, 1'b1, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h88F7, 4'd1, 16'h1111, 64, 16'h0001, 48'd5, 32'd100, 1'b0, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h88F7, 4'd0, 16'h2222, 30, 16'h0001, 48'd5, 32'd100, 1'b0, 1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h88F7, 4'd0, 16'h3333, 64, 16'h0001, 48'd6, 32'd7, VLAN_EXP, 1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h88F7, 4'd0, 16'h5555, 64, 16'h0001, 48'd5, 32'd100, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0800, 4'd0, 16'h6666, 64, 16'h0001, 48'd5, 32'd100, 1'b0, 1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h88F7, 4'd3, 16'hABCD, 64, 16'h0008, 48'd3, 32'd999_999_999, 1'b1, 1};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h88F7, 4'd2, 16'h4444, 46, 16'h0004, 48'hFFFF_FFFF_FFFF, 32'd0, 1'b1, 1};

    repeat (3) tick();
    check("reset_q_empty", 128'(empty), 128'(1));
    check("reset_q_count", 128'(count), 128'(0));
    check("reset_drop_cnt", 128'(drops), 128'(0));
    check("reset_rd_valid", 128'(rd_valid), 128'(0));
    check("reset_rd_data", 128'(rd_data), 128'(0));
    rst = 1'b0;
    tick();
    check("reset_sfd_pulse", 128'(sfd_cnt), 128'(0));

    // Latency carry across the second boundary on the LAT_NS=200 instance
    rtc_sec = 48'd7;
    rtc_ns  = 32'd999_999_900;
    sfd_cnt = 0;
    send_frame(1'b0, 1'b0, 16'h88F7, 4'd0, 16'h0007, 64);
    pop_lat(v, d);
    $display("lat frame: valid=%0d rec=%h", v, d);
    check("lat_valid", 128'(v), 128'(1));
    check("lat_rec", 128'(d), 128'({48'd8, 32'd100, 4'd0, 16'h0007}));
    pop_main(v, d);
    check("nolat_rec", 128'(d), 128'({48'd7, 32'd999_999_900, 4'd0, 16'h0007}));
    check("nolat_empty", 128'(empty), 128'(1));

    for (int k = 0; k < 9; k++) begin
      giga_mode = vecs[k].giga;
      mask      = vecs[k].mask;
      rtc_sec   = vecs[k].sec;
      rtc_ns    = vecs[k].ns;
      sfd_cnt   = 0;
      send_frame(vecs[k].bad_pre, vecs[k].vlan, vecs[k].et, vecs[k].mt, vecs[k].seq, vecs[k].nbytes);
      $display("vec %0d: giga=%0d seq=%h sfd=%0d count=%0d drops=%0d", k, vecs[k].giga,
               vecs[k].seq, sfd_cnt, count, drops);
      check($sformatf("v%0d_sfd_cnt", k), 128'(sfd_cnt), 128'(vecs[k].exp_sfd));
      check($sformatf("v%0d_q_count", k), 128'(count), 128'(vecs[k].exp_rec));
      check($sformatf("v%0d_drop_cnt", k), 128'(drops), 128'(0));
      if (vecs[k].exp_rec) begin
        pop_main(v, d);
        check($sformatf("v%0d_valid", k), 128'(v), 128'(1));
        check($sformatf("v%0d_rec", k), 128'(d),
              128'({vecs[k].sec, vecs[k].ns, vecs[k].mt, vecs[k].seq}));
      end
      check($sformatf("v%0d_empty", k), 128'(empty), 128'(1));
    end

    // DEPTH=4 overflow, FIFO order and empty-pop behaviour
    giga_mode = 1'b1;
    mask      = 16'h0001;
    rtc_sec   = 48'd1;
    rtc_ns    = 32'd1;
    for (int k = 0; k < 6; k++) send_frame(1'b0, 1'b0, 16'h88F7, 4'd0, 16'(16'h0100 + k), 64);
    $display("overflow: count=%0d drops=%0d", count, drops);
    check("ovf_q_count", 128'(count), 128'(4));
    check("ovf_drop_cnt", 128'(drops), 128'(2));
    for (int k = 0; k < 4; k++) begin
      pop_main(v, d);
      $display("pop %0d: valid=%0d seq=%h", k, v, d[15:0]);
      check($sformatf("pop%0d_valid", k), 128'(v), 128'(1));
      check($sformatf("pop%0d_seq", k), 128'(d[15:0]), 128'(16'h0100 + k));
    end
    check("drain_empty", 128'(empty), 128'(1));
    pop_main(v, d);
    check("empty_pop_valid", 128'(v), 128'(0));
    check("empty_pop_hold", 128'(d[15:0]), 128'(16'h0103));
    check("empty_pop_count", 128'(count), 128'(0));
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    tick();
    check("drop_clr", 128'(drops), 128'(0));

    // Reset in the middle of an otherwise eligible frame
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < 40; i++) send_byte(fbyte(i, 1'b0, 16'h88F7, 4'd0, 16'h7777));
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 40; i < 64; i++) send_byte(fbyte(i, 1'b0, 16'h88F7, 4'd0, 16'h7777));
    end_frame();
    $display("reset mid-frame: count=%0d empty=%0d", count, empty);
    check("rst_mid_count", 128'(count), 128'(0));
    check("rst_mid_empty", 128'(empty), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
